video_ram_write_scheduler: RTL

Owns the single write port of the video RAM window wrapper and shares it between two requesters.
- External pixel writer: valid/ready handshake, absolute screen coordinates.
- Internal fill engine: sweeps the whole window row-major with one colour, e.g. clearing the framebuffer after power-up.

Sits between the pixel-generating logic and the RAM wrapper. The wrapper's read side is untouched.

---
 rtl/video_ram_write_scheduler_pkg.sv | 23 ++
 rtl/video_ram_write_scheduler_if.sv | 34 +++
 rtl/video_ram_write_scheduler_window_fill_counter.sv | 42 ++++
 rtl/video_ram_write_scheduler.sv | 120 ++++++++++++
 4 files changed

// File: rtl/video_ram_write_scheduler_pkg.sv
// Shared screen constants, default widths and fill FSM encoding for the video RAM write scheduler.
package video_ram_write_scheduler_pkg;

    localparam int unsigned SCREEN_WIDTH        = 640;
    localparam int unsigned SCREEN_HEIGHT       = 480;
    localparam int unsigned SCREEN_CENTRE_X     = 320;
    localparam int unsigned SCREEN_CENTRE_Y     = 240;
    localparam int unsigned DEFAULT_COORD_WIDTH = 10;
    localparam int unsigned DEFAULT_DATA_WIDTH  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

    // Half-open span test done at 32 bits so lo+n can never wrap.
    function automatic logic in_span(input int unsigned v, input int unsigned lo,
                                     input int unsigned n);
        return (v >= lo) && (v < lo + n);
    endfunction

endpackage

// File: rtl/video_ram_write_scheduler_if.sv
// Host/fill request side and RAM write port of the scheduler, grouped as one bus.
interface video_ram_write_scheduler_if
    import video_ram_write_scheduler_pkg::*;
#(
    parameter int unsigned COORD_WIDTH = DEFAULT_COORD_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH
);
    logic                   iPixValid;
    logic                   oPixReady;
    logic [COORD_WIDTH-1:0] iPixRow;
    logic [COORD_WIDTH-1:0] iPixCol;
    logic [DATA_WIDTH-1:0]  iPixRGB;
    logic                   iFillStart;
    logic [DATA_WIDTH-1:0]  iFillRGB;
    logic                   oFillBusy;
    logic                   oFillDone;
    logic                   oDropped;
    logic                   oWriteEnable;
    logic [COORD_WIDTH-1:0] oWriteRow;
    logic [COORD_WIDTH-1:0] oWriteCol;
    logic [DATA_WIDTH-1:0]  oRGB;

    modport master (
        output iPixValid, iPixRow, iPixCol, iPixRGB, iFillStart, iFillRGB,
        input  oPixReady, oFillBusy, oFillDone, oDropped,
               oWriteEnable, oWriteRow, oWriteCol, oRGB
    );

    modport slave (
        input  iPixValid, iPixRow, iPixCol, iPixRGB, iFillStart, iFillRGB,
        output oPixReady, oFillBusy, oFillDone, oDropped,
               oWriteEnable, oWriteRow, oWriteCol, oRGB
    );
endinterface

// File: rtl/video_ram_write_scheduler_window_fill_counter.sv
// Row-major raster counter over a rectangular window; reusable for readout scanning.
module video_ram_write_scheduler_window_fill_counter #(
    parameter int unsigned COORD_WIDTH = 10,
    parameter int unsigned WIN_ROW0    = 190,
    parameter int unsigned WIN_COL0    = 270,
    parameter int unsigned WIN_ROWS    = 100,
    parameter int unsigned WIN_COLS    = 100
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   advance,
    output logic [COORD_WIDTH-1:0] row,
    output logic [COORD_WIDTH-1:0] col,
    output logic                   last
);
    localparam logic [COORD_WIDTH-1:0] FIRST_ROW = COORD_WIDTH'(WIN_ROW0);
    localparam logic [COORD_WIDTH-1:0] FIRST_COL = COORD_WIDTH'(WIN_COL0);
    localparam logic [COORD_WIDTH-1:0] LAST_ROW  = COORD_WIDTH'(WIN_ROW0 + WIN_ROWS - 1);
    localparam logic [COORD_WIDTH-1:0] LAST_COL  = COORD_WIDTH'(WIN_COL0 + WIN_COLS - 1);

    logic row_end;
    logic col_end;

    assign row_end = (row == LAST_ROW);
    assign col_end = (col == LAST_COL);
    assign last    = row_end && col_end;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row <= FIRST_ROW;
            col <= FIRST_COL;
        end else if (advance) begin
            if (col_end) begin
                col <= FIRST_COL;
                row <= row_end ? FIRST_ROW : row + COORD_WIDTH'(1);
            end else begin
                col <= col + COORD_WIDTH'(1);
            end
        end
    end
endmodule

// File: rtl/video_ram_write_scheduler.sv
// Shares the video RAM write port between host pixel writes (priority) and a window fill engine.
// Optional VBLANK_FILL_EN adds iVBlank and restricts fill grants to vertical blanking.
module video_ram_write_scheduler
    import video_ram_write_scheduler_pkg::*;
#(
    parameter int unsigned COORD_WIDTH = DEFAULT_COORD_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned WIN_ROW0    = 190,
    parameter int unsigned WIN_COL0    = 270,
    parameter int unsigned WIN_ROWS    = 100,
    parameter int unsigned WIN_COLS    = 100
) (
    input  logic CLK,
    input  logic Reset,
`ifdef VBLANK_FILL_EN
    input  logic iVBlank,
`endif
    video_ram_write_scheduler_if.slave bus
);
    fill_state_t            state;
    fill_state_t            state_nxt;
    logic [DATA_WIDTH-1:0]  fill_rgb;
    logic                   host_in_win;
    logic                   fill_ok;
    logic                   fill_grant;
    logic                   cnt_clear;
    logic                   cnt_last;
    logic [COORD_WIDTH-1:0] cnt_row;
    logic [COORD_WIDTH-1:0] cnt_col;
    logic                   we_q;
    logic                   dropped_q;
    logic [COORD_WIDTH-1:0] row_q;
    logic [COORD_WIDTH-1:0] col_q;
    logic [DATA_WIDTH-1:0]  rgb_q;

`ifdef VBLANK_FILL_EN
    assign fill_ok = iVBlank;
`else
    assign fill_ok = 1'b1;
`endif

    assign host_in_win = in_span(32'(bus.iPixRow), WIN_ROW0, WIN_ROWS) &&
                         in_span(32'(bus.iPixCol), WIN_COL0, WIN_COLS);

    video_ram_write_scheduler_window_fill_counter #(
        .COORD_WIDTH (COORD_WIDTH),
        .WIN_ROW0    (WIN_ROW0),
        .WIN_COL0    (WIN_COL0),
        .WIN_ROWS    (WIN_ROWS),
        .WIN_COLS    (WIN_COLS)
    ) u_counter (
        .clk     (CLK),
        .rst     (Reset),
        .clear   (cnt_clear),
        .advance (fill_grant),
        .row     (cnt_row),
        .col     (cnt_col),
        .last    (cnt_last)
    );

    // Fill FSM: the host always wins the port, fill only takes free cycles.
    always_comb begin
        state_nxt  = state;
        cnt_clear  = 1'b0;
        fill_grant = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.iFillStart) begin
                    state_nxt = ST_FILL;
                    cnt_clear = 1'b1;
                end
            end
            ST_FILL: begin
                fill_grant = !bus.iPixValid && fill_ok;
                if (fill_grant && cnt_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= ST_IDLE;
            fill_rgb  <= '0;
            we_q      <= 1'b0;
            dropped_q <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            rgb_q     <= '0;
        end else begin
            state     <= state_nxt;
            we_q      <= (bus.iPixValid && host_in_win) || fill_grant;
            dropped_q <= bus.iPixValid && !host_in_win;
            if (state == ST_IDLE && bus.iFillStart) begin
                fill_rgb <= bus.iFillRGB;
            end
            if (bus.iPixValid && host_in_win) begin
                row_q <= bus.iPixRow;
                col_q <= bus.iPixCol;
                rgb_q <= bus.iPixRGB;
            end else if (fill_grant) begin
                row_q <= cnt_row;
                col_q <= cnt_col;
                rgb_q <= fill_rgb;
            end
        end
    end

    assign bus.oPixReady    = !Reset;
    assign bus.oFillBusy    = (state == ST_FILL);
    assign bus.oFillDone    = (state == ST_DONE);
    assign bus.oDropped     = dropped_q;
    assign bus.oWriteEnable = we_q;
    assign bus.oWriteRow    = row_q;
    assign bus.oWriteCol    = col_q;
    assign bus.oRGB         = rgb_q;
endmodule
